// File: rtl/pc_next_unit.sv
// Program counter register, next-PC selection and fetch handshake for the single-cycle core.
// Optional jr alignment checking is enabled with `define ALIGN_CHECK_EN.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] FAULT_VECTOR = 32'h0000_0080,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fetch_req,
  output logic [31:0]      fetch_addr,
  input  logic             fetch_ack,
  input  logic             stall,
  input  logic             halt,
  input  logic             is_branch,
  input  logic             branch_taken,
  input  logic [31:0]      branch_offset,
  input  logic             is_jump,
  input  logic [27:0]      jump_target28,
  input  logic             is_jr,
  input  logic [31:0]      rs_value,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic             misalign_fault
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        commit;
  logic [31:0] jr_target;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  // Request is decoded from registered state only, so reset removes it immediately.
  assign fetch_req  = (state == ST_RUN) && !stall;
  assign commit     = fetch_req && fetch_ack;
  assign fetch_addr = pc;
  assign pc_plus4   = pc + 32'd4;
  assign halted     = (state == ST_HALT);

`ifdef ALIGN_CHECK_EN
  assign jr_misaligned = |rs_value[1:0];
  assign jr_target     = jr_misaligned ? FAULT_VECTOR : rs_value;
`else
  logic unused_align;
  assign unused_align  = ^{FAULT_VECTOR, rs_value[1:0]};
  assign jr_misaligned = 1'b0;
  assign jr_target     = {rs_value[31:2], 2'b00};
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    next_pc = pc_plus4;
    if (is_jr)
      next_pc = jr_target;
    else if (is_jump)
      next_pc = {pc_plus4[31:28], jump_target28};
    else if (is_branch && branch_taken)
      next_pc = pc_plus4 + branch_offset;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  if (halt && !stall) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_BOOT;
      pc             <= RESET_VECTOR;
      retired_cnt    <= '0;
      misalign_fault <= 1'b0;
    end else begin
      state          <= state_next;
      misalign_fault <= commit && is_jr && jr_misaligned;
      if (commit) begin
        pc          <= next_pc;
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: the driver queues expected fetch address/count,
// a negedge monitor pops and compares whenever fetch_req is presented.
module tb_pc_next_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        is_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = '0;
  logic        is_jump = 1'b0;
  logic [27:0] jump_target28 = '0;
  logic        is_jr = 1'b0;
  logic [31:0] rs_value = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_cnt;
  logic        halted;
  logic        misalign_fault;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

`ifdef ALIGN_CHECK_EN
  localparam logic [31:0] JR_MIS_PC = 32'h0000_0080;
  localparam logic        FAULT_EXP = 1'b1;
`else
  localparam logic [31:0] JR_MIS_PC = 32'h0000_2000;
  localparam logic        FAULT_EXP = 1'b0;
`endif

  pc_next_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .stall(stall), .halt(halt), .is_branch(is_branch),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .is_jump(is_jump),
    .jump_target28(jump_target28), .is_jr(is_jr), .rs_value(rs_value), .pc(pc),
    .pc_plus4(pc_plus4), .retired_cnt(retired_cnt), .halted(halted),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT requests a fetch, compare against the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && fetch_req) begin
      if (sb_q.size() == 0) begin
        check("unexpected_fetch_req", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("fetch_addr", fetch_addr, e.addr);
        check("pc", pc, e.addr);
        check("retired_cnt", retired_cnt, e.cnt);
      end
    end
  end

  task automatic clear_ctl();
    is_branch = 1'b0; branch_taken = 1'b0; branch_offset = '0;
    is_jump = 1'b0; jump_target28 = '0; is_jr = 1'b0; rs_value = '0;
  endtask

  // One clock of stimulus; controls are set beforehand, returns 1 ns after the next posedge.
  task automatic step(input logic ack, input logic st, input logic hl,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic [31:0] exp_cnt);
    exp_t e;
    fetch_ack = ack; stall = st; halt = hl;
    #1;
    if (exp_req) begin
      e.addr = exp_addr; e.cnt = exp_cnt;
      sb_q.push_back(e);
    end else begin
      check("fetch_req_low", {31'd0, fetch_req}, 32'd0);
    end
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_cnt", retired_cnt, 32'h0);
    check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, misalign_fault}, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch; BOOT cycle ignores ack.
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 1, 32'h0, 0);
    step(1, 0, 0, 1, 32'h4, 1);
    step(1, 0, 0, 1, 32'h8, 2);
    step(1, 0, 0, 1, 32'hC, 3);

    // Jump region from pc_plus4; jr beats jump.
    is_jr = 1; rs_value = 32'h0040_0010;
    step(1, 0, 0, 1, 32'h10, 4);
    is_jump = 1; jump_target28 = 28'h3575_444;
    step(1, 0, 0, 1, 32'h0040_0010, 5);
    is_jump = 1; jump_target28 = 28'h3575_444; is_jr = 1; rs_value = 32'h0000_1000;
    step(1, 0, 0, 1, 32'h0357_5444, 6);
    is_jr = 1; rs_value = 32'h0FFF_FFFC;
    step(1, 0, 0, 1, 32'h0000_1000, 7);
    is_jump = 1; jump_target28 = 28'h000_0010;
    step(1, 0, 0, 1, 32'h0FFF_FFFC, 8);

    // Branches, priority of jump over branch, wraparound.
    is_jr = 1; rs_value = 32'h0000_0100;
    step(1, 0, 0, 1, 32'h1000_0010, 9);
    is_branch = 1; branch_taken = 1; branch_offset = 32'hFFFF_FFF0;
    step(1, 0, 0, 1, 32'h0000_0100, 10);
    is_branch = 1; branch_taken = 0; branch_offset = 32'h0000_0100;
    step(1, 0, 0, 1, 32'h0000_00F4, 11);
    is_jr = 1; rs_value = 32'h0000_0100;
    step(1, 0, 0, 1, 32'h0000_00F8, 12);
    is_branch = 1;
    step(1, 0, 0, 1, 32'h0000_0100, 13);
    is_jump = 1; jump_target28 = 28'h000_0200;
    is_branch = 1; branch_taken = 1; branch_offset = 32'h40;
    step(1, 0, 0, 1, 32'h0000_0104, 14);
    is_jr = 1; rs_value = 32'hFFFF_FFFC;
    step(1, 0, 0, 1, 32'h0000_0200, 15);
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 16);
    is_branch = 1; branch_taken = 1; branch_offset = 32'hFFFF_FFF8;
    step(1, 0, 0, 1, 32'h0000_0000, 17);
    step(1, 0, 0, 1, 32'hFFFF_FFFC, 18);
    step(0, 0, 0, 1, 32'h0000_0000, 19);
    step(1, 0, 0, 1, 32'h0000_0000, 19);

    // Misaligned jr.
    is_jr = 1; rs_value = 32'h0000_2002;
    step(1, 0, 0, 1, 32'h0000_0004, 20);
    check("fault_pulse", {31'd0, misalign_fault}, {31'd0, FAULT_EXP});
    step(1, 0, 0, 1, JR_MIS_PC, 21);
    check("fault_clear", {31'd0, misalign_fault}, 32'd0);

    // Stall beats ack; halt while stalled does not halt.
    is_jr = 1; rs_value = 32'h0000_9000;
    step(1, 1, 0, 0, 32'h0, 0);
    step(1, 1, 0, 0, 32'h0, 0);
    step(1, 1, 1, 0, 32'h0, 0);
    check("stall_pc", pc, JR_MIS_PC + 32'd4);
    check("stall_cnt", retired_cnt, 32'd22);
    step(1, 0, 0, 1, JR_MIS_PC + 32'd4, 22);
    step(1, 0, 1, 1, JR_MIS_PC + 32'd8, 23);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, JR_MIS_PC + 32'd12);
    check("halt_cnt", retired_cnt, 32'd24);
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 32'h0, 0);
    check("halt_pc_hold", pc, JR_MIS_PC + 32'd12);
    check("halt_cnt_hold", retired_cnt, 32'd24);

    // Reset from HALT, then asynchronous reset in the middle of a RUN cycle.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 1, 32'h0, 0);
    step(1, 0, 0, 1, 32'h4, 1);
    fetch_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_req", {31'd0, fetch_req}, 32'd0);
    check("async_rst_cnt", retired_cnt, 32'h0);
    check("async_rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
